// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if
// Request/response bundle between the main control unit, the ALU control
// block and the ALU/mult-div unit.
//   in_valid/in_ready : request handshake (control unit -> block)
//   aluop/funct       : request payload
//   out_valid/out_ready: response handshake (block -> ALU)
//   select/illegal    : response payload
//   busy              : multi-cycle operation in progress
// Modports: master = requester/consumer side, slave = the decoder block.
interface alu_control_mc_if #(
  parameter int FUNCT_W = 6,
  parameter int SEL_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         aluop;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   select;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, aluop, funct, out_ready,
    input  in_ready, out_valid, select, illegal, busy
  );

  modport slave (
    input  in_valid, aluop, funct, out_ready,
    output in_ready, out_valid, select, illegal, busy
  );
endinterface

// File: rtl/alu_control_mc.sv
// alu_control_mc
// Registered ALU control decoder with valid/ready handshakes on both sides.
// Decodes aluop/funct into an ALU select code; MULT and DIV hold the block
// in a countdown state so out_valid appears exactly MUL_CYCLES / DIV_CYCLES
// cycles after the accepting edge.
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   bus (slave)   : request/response bundle, see alu_control_mc_if
//   op_count      : output handshake counter (ALUCTRL_STATS_EN only)
//   illegal_count : illegal output handshake counter (ALUCTRL_STATS_EN only)
// Optional feature macro: ALUCTRL_STATS_EN adds the saturating counters.
module alu_control_mc #(
  parameter int FUNCT_W    = 6,
  parameter int SEL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_control_mc_if.slave bus
`ifdef ALUCTRL_STATS_EN
  ,
  output logic [15:0]     op_count,
  output logic [7:0]      illegal_count
`endif
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  // Decode result: [6] multi-cycle, [5] divide, [4] illegal, [3:0] select.
  function automatic logic [6:0] decode(input logic [1:0] op,
                                        input logic [FUNCT_W-1:0] f);
    logic [6:0] r;
    r = {3'b001, 4'b0011};
    case (op)
      2'b00: r = {3'b000, 4'b0010};
      2'b01: r = {3'b000, 4'b0110};
      2'b10: begin
        // Any set bit above the decoded 6-bit field makes the request illegal.
        if ((f >> 6) == '0) begin
          case (f[5:0])
            6'b100000: r = {3'b000, 4'b0010};
            6'b100010: r = {3'b000, 4'b0110};
            6'b100100: r = {3'b000, 4'b0000};
            6'b100101: r = {3'b000, 4'b0001};
            6'b101010: r = {3'b000, 4'b0111};
            6'b100111: r = {3'b000, 4'b1100};
            6'b000000: r = {3'b000, 4'b1000};
            6'b000010: r = {3'b000, 4'b1001};
            6'b011000: r = {3'b100, 4'b1010};
            6'b011010: r = {3'b110, 4'b1011};
            default:   r = {3'b001, 4'b0011};
          endcase
        end
      end
      default: r = {3'b001, 4'b0011};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             illegal_q, illegal_d;
  logic             in_ready;
  logic             accept;
  logic [6:0]       dec;

  assign in_ready = !rst && ((state_q == S_IDLE) ||
                             ((state_q == S_OUT) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign dec      = decode(bus.aluop, bus.funct);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    select_d  = select_q;
    illegal_d = illegal_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_OUT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    // A new accept overrides the retire path, giving bubble-free streaming.
    if (accept) begin
      select_d  = SEL_W'(dec[3:0]);
      illegal_d = dec[4];
      if (dec[6]) begin
        state_d = S_WAIT;
        // WAIT lasts CYCLES-1 cycles, so the OUT state lands CYCLES after accept.
        cnt_d   = dec[5] ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
      end else begin
        state_d = S_OUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      select_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q == S_WAIT);
  assign bus.select    = select_q;
  assign bus.illegal   = illegal_q;

`ifdef ALUCTRL_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [7:0]  illegal_count_q, illegal_count_d;
  logic        out_hs;

  assign out_hs = (state_q == S_OUT) && bus.out_ready;

  always_comb begin
    op_count_d      = op_count_q;
    illegal_count_d = illegal_count_q;
    if (out_hs && (op_count_q != '1))
      op_count_d = op_count_q + 1'b1;
    if (out_hs && illegal_q && (illegal_count_q != '1))
      illegal_count_d = illegal_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q      <= '0;
      illegal_count_q <= '0;
    end else begin
      op_count_q      <= op_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign op_count      = op_count_q;
  assign illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc
// Directed self-checking bench for alu_control_mc (default parameters).
module tb_alu_control_mc;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_control_mc_if #(.FUNCT_W(6), .SEL_W(4)) bus ();

`ifdef ALUCTRL_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  illegal_count;
`endif

  alu_control_mc #(
    .FUNCT_W(6), .SEL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALUCTRL_STATS_EN
    ,
    .op_count(op_count),
    .illegal_count(illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] s_op  [8];
  logic [5:0] s_fn  [8];
  logic [3:0] s_sel [8];

  initial begin
    tests = 0;
    fails = 0;
    s_op  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    s_fn  = '{6'b000000, 6'b100010, 6'b100111, 6'b000010,
              6'b100100, 6'b100101, 6'b101010, 6'b000000};
    s_sel = '{4'h2, 4'h6, 4'hC, 4'h9, 4'h0, 4'h1, 4'h7, 4'h8};

    // Reset for two cycles
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.aluop     = 2'b10;
    bus.funct     = 6'b100000;
    bus.out_ready = 1'b1;
    #1;
    chk("in_ready_in_rst", bus.in_ready, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_select", bus.select, 4'h0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);

    // Single add, latency 1
    rst = 1'b0;
    #1;
    chk("add_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("add_out_valid", bus.out_valid, 1'b1);
    chk("add_select", bus.select, 4'h2);
    chk("add_illegal", bus.illegal, 1'b0);
    tick();
    chk("add_retire", bus.out_valid, 1'b0);

    // Sub held while ALU stalls
    bus.in_valid  = 1'b1;
    bus.aluop     = 2'b01;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("sub_hold_valid", bus.out_valid, 1'b1);
      chk("sub_hold_select", bus.select, 4'h6);
      chk("sub_hold_in_ready", bus.in_ready, 1'b0);
      if (c < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("sub_hs_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("sub_idle_valid", bus.out_valid, 1'b0);
    chk("sub_idle_select_hold", bus.select, 4'h6);
    chk("sub_idle_in_ready", bus.in_ready, 1'b1);

    // MULT: busy cycles 1-3, out_valid at cycle 4; in_valid ignored in WAIT
    bus.in_valid = 1'b1;
    bus.aluop    = 2'b10;
    bus.funct    = 6'b011000;
    tick();
    bus.aluop = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      chk("mul_busy", bus.busy, 1'b1);
      chk("mul_no_valid", bus.out_valid, 1'b0);
      chk("mul_in_ready", bus.in_ready, 1'b0);
      chk("mul_select_early", bus.select, 4'hA);
      if (c == 3) bus.in_valid = 1'b0;
      tick();
    end
    chk("mul_out_valid", bus.out_valid, 1'b1);
    chk("mul_busy_done", bus.busy, 1'b0);
    chk("mul_select", bus.select, 4'hA);
    tick();
    chk("mul_retire", bus.out_valid, 1'b0);

    // DIV: out_valid at cycle 8
    bus.in_valid = 1'b1;
    bus.aluop    = 2'b10;
    bus.funct    = 6'b011010;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("div_busy", bus.busy, 1'b1);
      chk("div_no_valid", bus.out_valid, 1'b0);
      tick();
    end
    chk("div_out_valid", bus.out_valid, 1'b1);
    chk("div_select", bus.select, 4'hB);
    chk("div_illegal", bus.illegal, 1'b0);
    tick();
    chk("div_retire", bus.out_valid, 1'b0);

    // Fresh counters, then two back-to-back illegal requests
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.aluop    = 2'b11;
    tick();
    chk("ill_op_valid", bus.out_valid, 1'b1);
    chk("ill_op_select", bus.select, 4'h3);
    chk("ill_op_illegal", bus.illegal, 1'b1);
    bus.aluop = 2'b10;
    bus.funct = 6'b111111;
    tick();
    chk("ill_fn_valid", bus.out_valid, 1'b1);
    chk("ill_fn_select", bus.select, 4'h3);
    chk("ill_fn_illegal", bus.illegal, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("ill_retire", bus.out_valid, 1'b0);
`ifdef ALUCTRL_STATS_EN
    chk("stats_op_count", op_count, 16'd2);
    chk("stats_illegal_count", illegal_count, 8'd2);
`endif

    // Streaming: one output per cycle, no bubbles
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.aluop = s_op[i];
      bus.funct = s_fn[i];
      tick();
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_select", bus.select, s_sel[i]);
      chk("stream_illegal", bus.illegal, 1'b0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_retire", bus.out_valid, 1'b0);

    // Reset during the third WAIT cycle of a DIV
    bus.in_valid = 1'b1;
    bus.aluop    = 2'b10;
    bus.funct    = 6'b011010;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_select", bus.select, 4'h0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.funct    = 6'b100000;
    tick();
    bus.in_valid = 1'b0;
    chk("post_abort_valid", bus.out_valid, 1'b1);
    chk("post_abort_select", bus.select, 4'h2);
    tick();
    chk("post_abort_retire", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
